// File: rtl/serial_tx_queue.sv
// serial_tx_queue: FIFO-buffered frame serialiser driving a released (Z when idle) one-wire line.
// Optional feature macro: SERIAL_TX_PARITY_EN appends an even-parity bit after the data bits.
module serial_tx_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 5,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [LEN_WIDTH-1:0]    bit_length,
  input  logic                    msb_first,
  output logic                    dout,
  output logic                    tx_busy,
  output logic                    data_sent,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(DATA_WIDTH);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [LEN_WIDTH-1:0]  mem_len  [DEPTH];
  logic                  mem_msb  [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;
  logic [LEN_WIDTH-1:0]  len_in;

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  msb_q, msb_d;
  logic                  line_q, line_d;
  logic                  drive_d;
  logic                  cur_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign push       = din_valid && din_ready;
  assign len_in     = (bit_length > MAX_LEN) ? MAX_LEN : bit_length;
  assign fifo_count = count_q;
  assign dout       = tx_busy ? line_q : 1'bz;

  // Occupancy: pushes and pops in the same cycle cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      din_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q   <= count_d;
      din_ready <= (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= din;
      mem_len[wr_ptr]  <= len_in;
      mem_msb[wr_ptr]  <= msb_first;
    end
  end

  // MSB-first frames are left-aligned on load so both orders shift out of a fixed end
  assign cur_bit = msb_q ? sr_q[DATA_WIDTH-1] : sr_q[0];

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    pop     = 1'b0;
    drive_d = 1'b0;
    line_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          cnt_d = mem_len[rd_ptr];
          msb_d = mem_msb[rd_ptr];
          sr_d  = mem_msb[rd_ptr] ? (mem_data[rd_ptr] << (MAX_LEN - mem_len[rd_ptr]))
                                  : mem_data[rd_ptr];
`ifdef SERIAL_TX_PARITY_EN
          par_d = 1'b0;
`endif
          if (mem_len[rd_ptr] != '0) state_d = START;
        end
      end
      START: begin
        drive_d = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        drive_d = 1'b1;
        line_d  = cur_bit;
        cnt_d   = cnt_q - LEN_WIDTH'(1);
        sr_d    = msb_q ? (sr_q << 1) : (sr_q >> 1);
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q ^ cur_bit;
        if (cnt_q == LEN_WIDTH'(1)) state_d = PARITY;
`else
        if (cnt_q == LEN_WIDTH'(1)) state_d = IDLE;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        drive_d = 1'b1;
        line_d  = par_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Line outputs lag the state by one edge; completion is the first IDLE cycle after driving
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      msb_q     <= 1'b0;
      line_q    <= 1'b0;
      tx_busy   <= 1'b0;
      data_sent <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      msb_q     <= msb_d;
      line_q    <= line_d;
      tx_busy   <= drive_d;
      data_sent <= (state_q == IDLE) && tx_busy;
`ifdef SERIAL_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_queue.sv
// Scoreboard bench for serial_tx_queue: expected frames are queued at push time, a monitor checks the line.
module tb_serial_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din;
  logic [4:0]  bit_length;
  logic        msb_first;
  wire         dout;
  logic        tx_busy;
  logic        data_sent;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          n;
    logic [31:0] bits;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];

  bit          in_frame = 1'b0;
  int          nb = 0;
  logic [31:0] bits = '0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_end = -100;

  serial_tx_queue #(.DATA_WIDTH(16), .LEN_WIDTH(5), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din        (din),
    .bit_length (bit_length),
    .msb_first  (msb_first),
    .dout       (dout),
    .tx_busy    (tx_busy),
    .data_sent  (data_sent),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected bits are written in transmit order (first bit is the MSB of b)
  function automatic void expect_frame(int n, logic [31:0] b, bit b2b);
    exp_t e;
    e.n    = n;
    e.bits = b;
    e.b2b  = b2b;
`ifdef SERIAL_TX_PARITY_EN
    e.bits = {b[30:0], ^b};
    e.n    = n + 1;
`endif
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [4:0] len, input logic msb);
    din        = d;
    bit_length = len;
    msb_first  = msb;
    din_valid  = 1'b1;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || in_frame || fifo_count != 3'd0 || tx_busy) && k < 300) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL wait_idle: timeout with %0d frames outstanding", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Line monitor: frames the serial stream by tx_busy and pops the scoreboard on completion
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (data_sent !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL spurious_data_sent: got %b expected 0 at cycle %0d", data_sent, cyc);
      end
      if (tx_busy === 1'b1) begin
        in_frame  = 1'b1;
        nb        = 0;
        bits      = '0;
        start_cyc = cyc;
        checks++;
        if (dout !== 1'b0) begin
          errors++;
          $display("FAIL start_bit: got %b expected 0", dout);
        end
      end
    end else if (tx_busy === 1'b1) begin
      if (data_sent !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL data_sent_midframe: got %b expected 0", data_sent);
      end
      bits = {bits[30:0], dout};
      nb++;
    end else begin
      in_frame = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame: got %0d bits %h expected no frame", nb, bits);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (nb != e.n || bits !== e.bits) begin
          errors++;
          $display("FAIL frame_bits: got n=%0d bits=%h expected n=%0d bits=%h", nb, bits, e.n, e.bits);
        end
        if (e.b2b) begin
          checks++;
          if (start_cyc != last_end + 1) begin
            errors++;
            $display("FAIL frame_gap: got start %0d expected %0d", start_cyc, last_end + 1);
          end
        end
      end
      checks++;
      if (data_sent !== 1'b1) begin
        errors++;
        $display("FAIL data_sent_missing: got %b expected 1", data_sent);
      end
      last_end = cyc;
    end
  end

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    bit_length = '0;
    msb_first  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_busy", 32'(tx_busy), 32'd0);
    chk("reset_data_sent", 32'(data_sent), 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_din_ready", 32'(din_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single MSB-first frame with latency checks
    expect_frame(8, 32'b10100101, 1'b0);
    push(16'h00A5, 5'd8, 1'b1);
    chk("count_after_push", 32'(fifo_count), 32'd1);
    @(posedge clk); #1;
    chk("pop_cycle_idle", 32'(tx_busy), 32'd0);
    chk("pop_cycle_count", 32'(fifo_count), 32'd0);
    @(posedge clk); #1;
    chk("start_cycle_busy", 32'(tx_busy), 32'd1);
    wait_idle();

    // LSB-first frames
    expect_frame(8, 32'b10100101, 1'b0);
    push(16'h00A5, 5'd8, 1'b0);
    wait_idle();
    expect_frame(8, 32'b10000000, 1'b0);
    push(16'h0001, 5'd8, 1'b0);
    wait_idle();

    // Burst of five 3-bit frames into a 4-deep FIFO, sixth push refused
    expect_frame(3, 32'b101, 1'b0);
    expect_frame(3, 32'b011, 1'b1);
    expect_frame(3, 32'b001, 1'b1);
    expect_frame(3, 32'b110, 1'b1);
    expect_frame(3, 32'b001, 1'b1);
    push(16'h0005, 5'd3, 1'b1);
    push(16'h0006, 5'd3, 1'b0);
    push(16'h0001, 5'd3, 1'b1);
    push(16'h0006, 5'd3, 1'b1);
    push(16'h0004, 5'd3, 1'b0);
    chk("burst_count_full", 32'(fifo_count), 32'd4);
    chk("burst_ready_low", 32'(din_ready), 32'd0);
    push(16'h0007, 5'd3, 1'b1);
    chk("burst_count_after_refused", 32'(fifo_count), 32'd4);
    chk("burst_ready_still_low", 32'(din_ready), 32'd0);
    wait_idle();

    // Zero-length frame: consumed silently
    push(16'h00FF, 5'd0, 1'b1);
    chk("len0_queued", 32'(fifo_count), 32'd1);
    wait_idle();
    repeat (8) @(posedge clk); #1;
    chk("len0_drained", 32'(fifo_count), 32'd0);
    chk("len0_no_busy", 32'(tx_busy), 32'd0);

    // Over-length frame clamps to 16 bits
    expect_frame(16, 32'b1010010111000011, 1'b0);
    push(16'hA5C3, 5'd31, 1'b1);
    wait_idle();

    // Single-bit frame
    expect_frame(1, 32'b1, 1'b0);
    push(16'h0001, 5'd1, 1'b1);
    wait_idle();

    // Parity reference frame (parity bit appended only in the parity build)
    expect_frame(3, 32'b111, 1'b0);
    push(16'h0007, 5'd3, 1'b1);
    wait_idle();

    // Reset during the 4th data bit of 0xB4 with two frames queued
    push(16'h00B4, 5'd8, 1'b1);
    push(16'h0055, 5'd8, 1'b1);
    push(16'h00AA, 5'd8, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(tx_busy), 32'd1);
    chk("abort_bit4", 32'(dout), 32'd1);
    chk("abort_queued", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_tx_busy", 32'(tx_busy), 32'd0);
    chk("abort_fifo_count", 32'(fifo_count), 32'd0);
    chk("abort_din_ready", 32'(din_ready), 32'd1);
    chk("abort_data_sent", 32'(data_sent), 32'd0);
    repeat (20) @(posedge clk); #1;
    chk("abort_quiet_busy", 32'(tx_busy), 32'd0);
    chk("abort_quiet_count", 32'(fifo_count), 32'd0);

    chk("leftover_frames", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_tx_queue.md
Name: serial_tx_queue

Overview:
- Parameterised, queued successor to the single-frame parallel-to-serial converter.
- Accepts frames of up to DATA_WIDTH bits through a valid/ready push port and stores them in a DEPTH-entry FIFO.
- Each frame has its own bit length and bit order. Frames are serialised onto a one-wire bus as: start bit (0), data bits, optional parity bit.
- The line is released (Z) between frames. Sits between a bus-master controller and the shared serial bus line.

Parameters:
DATA_WIDTH, 16, maximum data bits per frame
LEN_WIDTH, 5, width of bit_length; must satisfy 2**LEN_WIDTH > DATA_WIDTH
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
din_valid  input  1  push request
din_ready  output  1  FIFO can accept a frame; equals !full
din  input  DATA_WIDTH  frame payload, right-aligned
bit_length  input  LEN_WIDTH  data bits in frame, sampled with din
msb_first  input  1  1: send bit_length-1 down to 0; 0: send 0 up to bit_length-1; sampled with din
dout  output  1  serial line; 1'bZ when not transmitting
tx_busy  output  1  high while START/DATA/PARITY states drive dout
data_sent  output  1  one-cycle pulse on frame completion
fifo_count  output  $clog2(DEPTH)+1  frames queued, excluding the frame in flight

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: dout=Z, tx_busy=0, data_sent=0, fifo_count=0, din_ready=1. FIFO pointers and FSM are cleared.
- Reset asserted mid-frame takes effect at the next edge: the frame is aborted, dout=Z, all queued frames are flushed, and no data_sent pulse is issued.
- Push: a frame is stored when din_valid && din_ready at a rising edge. {din, bit_length, msb_first} are written together.
- Push while full: ignored (din_ready=0). Ready does not consider a same-cycle pop, so push into a full FIFO is never accepted.
- Frame lengths:
  - bit_length > DATA_WIDTH: clamped to DATA_WIDTH when the frame is stored.
  - bit_length == 0: stored, then discarded when popped. No line activity, no data_sent, and the FSM stays IDLE for that cycle.
- FSM states: IDLE, START, DATA, PARITY (PARITY exists only with the optional feature).
- IDLE:
  - dout=Z, tx_busy=0.
  - If the FIFO is non-empty, pop the head into the shift register and the bit counter.
  - Go to START, or stay in IDLE if the popped length is 0.
- START: dout=0, tx_busy=1. Next state is DATA.
- DATA:
  - dout = current bit, selected per msb_first.
  - The counter decrements each cycle. After the bit_length-th bit, go to PARITY if enabled, otherwise IDLE.
- Completion: data_sent=1 for exactly the cycle in which the FSM re-enters IDLE, which is the cycle dout returns to Z. data_sent is 0 at all other times.
- Latency:
  - Push into an empty FIFO while IDLE at edge t: pop at t+1, start bit driven t+2, data bits t+3 .. t+2+N, data_sent and Z at t+3+N.
  - Back-to-back frames: the next frame pops in the same cycle as data_sent, so exactly one Z cycle separates frames.
- Simultaneous push and pop: permitted when not full; fifo_count is unchanged.
- fifo_count updates on the edge after a push or pop.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY and drives one even-parity bit (XOR of the bit_length transmitted bits), with tx_busy=1.
  - data_sent then fires one cycle later than without parity (t+4+N in the latency example).
- Undefined: the PARITY state and its logic are absent; DATA goes directly to IDLE.

Test Plan:
- Reset then single push: din=16'h00A5, bit_length=8, msb_first=1.
  - dout: Z, 0, then 1,0,1,0,0,1,0,1, then Z.
  - data_sent pulses one cycle, at the Z after the last bit. With parity, a bit 0 is inserted before Z.
- Same push with msb_first=0 -> data bits 1,0,1,0,0,1,0,1 (LSB first; pattern symmetric), then repeat with din=8'h01 LSB-first -> 1,0,0,0,0,0,0,0.
- Push 5 frames (bit_length=3) back-to-back with DEPTH=4 while IDLE.
  - First frame pops, 4 are queued, fifo_count reaches 4, din_ready=0.
  - The 6th push is ignored.
  - Frames drain with exactly one Z cycle between them, and 5 data_sent pulses in total.
- Boundary lengths:
  - bit_length=0 -> no line activity, no data_sent.
  - bit_length=31 with DATA_WIDTH=16 -> exactly 16 data bits sent.
  - bit_length=1, din=1 -> Z,0,1,Z.
- Assert rst during the 4th data bit of an 8-bit frame with 2 frames queued.
  - Next edge: dout=Z, fifo_count=0, din_ready=1, no data_sent.
  - No further line activity.
- Parity build: din=16'h0007, bit_length=3 -> dout 0,1,1,1 then parity 1, then Z with data_sent.
